// File: rtl/ppc_types.sv
// Shared types for the PowerPC core: decoded multiply control and the
// generic reservation-station operand record.
package ppc_types;

  localparam int RS_TAG_W = 5;

  typedef struct packed {
    logic [1:0] op;
    logic       oe;
    logic       rc;
  } mul_decode_t;

  typedef struct packed {
    logic                valid;
    logic [RS_TAG_W-1:0] tag;
    logic [31:0]         value;
  } rs_operand_t;

endpackage

// File: rtl/rs_operand_capture.sv
// One operand slot of a reservation-station entry: takes the dispatched value
// or waits on a producer tag and snoops the CDB until the value appears.
module rs_operand_capture #(
  parameter int ID_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            busy,
  input  logic            src_valid,
  input  logic [31:0]     src_value,
  input  logic [ID_W-1:0] src_tag,
  input  logic            cdb_valid,
  input  logic [ID_W-1:0] cdb_tag,
  input  logic [31:0]     cdb_value,
  input  logic            cdb_value_valid,
  output logic            valid,
  output logic [31:0]     value
);

  logic [ID_W-1:0] tag;
  logic            hit_new;
  logic            hit_wait;

  // hit_new forwards a broadcast landing in the same cycle as the dispatch
  assign hit_new  = cdb_valid & cdb_value_valid & (cdb_tag == src_tag);
  assign hit_wait = busy & ~valid & cdb_valid & cdb_value_valid & (cdb_tag == tag);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      value <= '0;
      tag   <= '0;
    end else if (load) begin
      tag <= src_tag;
      if (src_valid) begin
        valid <= 1'b1;
        value <= src_value;
      end else if (hit_new) begin
        valid <= 1'b1;
        value <= cdb_value;
      end else begin
        valid <= 1'b0;
        value <= src_value;
      end
    end else if (hit_wait) begin
      valid <= 1'b1;
      value <= cdb_value;
    end
  end

endmodule

// File: rtl/mul_reservation_station.sv
// Reservation station feeding the multiply unit: holds dispatched multiplies
// until their operands resolve, then issues the lowest-index ready entry.
module mul_reservation_station
  import ppc_types::*;
#(
  parameter int RS_ID_WIDTH = 5,
  parameter int RS_OFFSET   = 0,
  parameter int RS_DEPTH    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   dispatch_valid,
  output logic                   dispatch_ready,
  output logic [RS_ID_WIDTH-1:0] dispatch_rs_id,
  input  logic                   op1_valid_in,
  input  logic                   op2_valid_in,
  input  logic                   xer_valid_in,
  input  logic [31:0]            op1_in,
  input  logic [31:0]            op2_in,
  input  logic [31:0]            xer_in,
  input  logic [RS_ID_WIDTH-1:0] op1_rs_id_in,
  input  logic [RS_ID_WIDTH-1:0] op2_rs_id_in,
  input  logic [RS_ID_WIDTH-1:0] xer_rs_id_in,
  input  logic [4:0]             result_reg_addr_in,
  input  mul_decode_t            control_in,
  input  logic                   cdb_valid,
  input  logic [RS_ID_WIDTH-1:0] cdb_rs_id,
  input  logic [31:0]            cdb_result,
  input  logic [31:0]            cdb_xer,
  input  logic                   cdb_xer_valid,
  output logic                   issue_valid,
  input  logic                   issue_ready,
  output logic [RS_ID_WIDTH-1:0] issue_rs_id,
  output logic [4:0]             issue_result_reg_addr,
  output logic [31:0]            issue_op1,
  output logic [31:0]            issue_op2,
  output logic [31:0]            issue_xer,
  output mul_decode_t            issue_control
);

  localparam int IDX_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

  logic [RS_DEPTH-1:0] busy, load, take;
  logic [RS_DEPTH-1:0] op1_v, op2_v, xer_v;
  logic [31:0]         op1_val [RS_DEPTH];
  logic [31:0]         op2_val [RS_DEPTH];
  logic [31:0]         xer_val [RS_DEPTH];
  logic [4:0]          dest    [RS_DEPTH];
  mul_decode_t         ctrl    [RS_DEPTH];

  logic             any_free, any_ready, out_load;
  logic [IDX_W-1:0] free_idx, ready_idx;

  // Descending scans leave the lowest qualifying index as the winner
  always_comb begin
    any_free  = 1'b0;
    free_idx  = '0;
    any_ready = 1'b0;
    ready_idx = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        any_free = 1'b1;
        free_idx = IDX_W'(i);
      end
      if (busy[i] && op1_v[i] && op2_v[i] && xer_v[i]) begin
        any_ready = 1'b1;
        ready_idx = IDX_W'(i);
      end
    end
  end

  assign dispatch_ready = any_free;
  assign dispatch_rs_id = RS_ID_WIDTH'(RS_OFFSET) + RS_ID_WIDTH'(free_idx);
  assign out_load       = ~issue_valid | issue_ready;

  for (genvar i = 0; i < RS_DEPTH; i++) begin : g_entry
    assign load[i] = dispatch_valid & any_free & (free_idx == IDX_W'(i));
    assign take[i] = out_load & any_ready & (ready_idx == IDX_W'(i));

    rs_operand_capture #(.ID_W(RS_ID_WIDTH)) u_op1 (
      .clk(clk), .rst(rst), .load(load[i]), .busy(busy[i]),
      .src_valid(op1_valid_in), .src_value(op1_in), .src_tag(op1_rs_id_in),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_rs_id), .cdb_value(cdb_result),
      .cdb_value_valid(1'b1), .valid(op1_v[i]), .value(op1_val[i])
    );

    rs_operand_capture #(.ID_W(RS_ID_WIDTH)) u_op2 (
      .clk(clk), .rst(rst), .load(load[i]), .busy(busy[i]),
      .src_valid(op2_valid_in), .src_value(op2_in), .src_tag(op2_rs_id_in),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_rs_id), .cdb_value(cdb_result),
      .cdb_value_valid(1'b1), .valid(op2_v[i]), .value(op2_val[i])
    );

    rs_operand_capture #(.ID_W(RS_ID_WIDTH)) u_xer (
      .clk(clk), .rst(rst), .load(load[i]), .busy(busy[i]),
      .src_valid(xer_valid_in), .src_value(xer_in), .src_tag(xer_rs_id_in),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_rs_id), .cdb_value(cdb_xer),
      .cdb_value_valid(cdb_xer_valid), .valid(xer_v[i]), .value(xer_val[i])
    );
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (rst)          busy[i] <= 1'b0;
      else if (load[i]) busy[i] <= 1'b1;
      else if (take[i]) busy[i] <= 1'b0;
      if (load[i]) begin
        dest[i] <= result_reg_addr_in;
        ctrl[i] <= control_in;
      end
    end
  end

  // Issue register: refills whenever empty or drained this cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_valid           <= 1'b0;
      issue_rs_id           <= '0;
      issue_result_reg_addr <= '0;
      issue_op1             <= '0;
      issue_op2             <= '0;
      issue_xer             <= '0;
      issue_control         <= '0;
    end else if (out_load) begin
      issue_valid <= any_ready;
      if (any_ready) begin
        issue_rs_id           <= RS_ID_WIDTH'(RS_OFFSET) + RS_ID_WIDTH'(ready_idx);
        issue_result_reg_addr <= dest[ready_idx];
        issue_op1             <= op1_val[ready_idx];
        issue_op2             <= op2_val[ready_idx];
        issue_xer             <= xer_val[ready_idx];
        issue_control         <= ctrl[ready_idx];
      end
    end
  end

endmodule

// File: tb/tb_mul_reservation_station.sv
// Bench for mul_reservation_station: vector table, directed corner sequences
// and a randomized run, all cross-checked against a cycle-level reference.
module tb_mul_reservation_station;
  import ppc_types::*;

  localparam int IDW   = 5;
  localparam int OFF   = 8;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, dispatch_valid, dispatch_ready;
  logic [IDW-1:0] dispatch_rs_id;
  logic op1_valid_in, op2_valid_in, xer_valid_in;
  logic [31:0] op1_in, op2_in, xer_in;
  logic [IDW-1:0] op1_rs_id_in, op2_rs_id_in, xer_rs_id_in;
  logic [4:0] result_reg_addr_in;
  mul_decode_t control_in;
  logic cdb_valid, cdb_xer_valid;
  logic [IDW-1:0] cdb_rs_id;
  logic [31:0] cdb_result, cdb_xer;
  logic issue_valid, issue_ready;
  logic [IDW-1:0] issue_rs_id;
  logic [4:0] issue_result_reg_addr;
  logic [31:0] issue_op1, issue_op2, issue_xer;
  mul_decode_t issue_control;
  logic [3:0] ic;
  assign ic = issue_control;

  mul_reservation_station #(.RS_ID_WIDTH(IDW), .RS_OFFSET(OFF), .RS_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready), .dispatch_rs_id(dispatch_rs_id),
    .op1_valid_in(op1_valid_in), .op2_valid_in(op2_valid_in), .xer_valid_in(xer_valid_in),
    .op1_in(op1_in), .op2_in(op2_in), .xer_in(xer_in),
    .op1_rs_id_in(op1_rs_id_in), .op2_rs_id_in(op2_rs_id_in), .xer_rs_id_in(xer_rs_id_in),
    .result_reg_addr_in(result_reg_addr_in), .control_in(control_in),
    .cdb_valid(cdb_valid), .cdb_rs_id(cdb_rs_id), .cdb_result(cdb_result),
    .cdb_xer(cdb_xer), .cdb_xer_valid(cdb_xer_valid),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_rs_id(issue_rs_id),
    .issue_result_reg_addr(issue_result_reg_addr),
    .issue_op1(issue_op1), .issue_op2(issue_op2), .issue_xer(issue_xer),
    .issue_control(issue_control)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: each entry is a record of operand slots; each cycle applies the
  // snoop, issue and dispatch rules to the state held at the start of the cycle.
  typedef struct packed {
    logic                  busy;
    logic [2:0]            v;
    logic [2:0][IDW-1:0]   tag;
    logic [2:0][31:0]      val;
    logic [4:0]            dest;
    logic [3:0]            ctrl;
  } ent_t;

  ent_t        m_ent [DEPTH];
  logic        m_iv;
  logic [IDW-1:0] m_id;
  logic [4:0]  m_dest;
  logic [3:0]  m_ctrl;
  logic [31:0] m_op [3];
  bit          m_known = 0;

  function automatic int m_free();
    for (int i = 0; i < DEPTH; i++) if (!m_ent[i].busy) return i;
    return -1;
  endfunction

  function automatic int m_ready();
    for (int i = 0; i < DEPTH; i++) if (m_ent[i].busy && m_ent[i].v == 3'b111) return i;
    return -1;
  endfunction

  function automatic bit cdb_hits(input int k, input logic [IDW-1:0] t);
    return cdb_valid && (cdb_rs_id == t) && (k < 2 || cdb_xer_valid);
  endfunction

  task automatic model_step();
    ent_t nxt [DEPTH];
    int f, r;
    logic [2:0] inv;
    logic [2:0][31:0] inval, cval;
    logic [2:0][IDW-1:0] intag;
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) m_ent[i] = '0;
      m_iv = 0; m_id = '0; m_dest = '0; m_ctrl = '0;
      for (int k = 0; k < 3; k++) m_op[k] = '0;
      m_known = 1;
    end else begin
      f = m_free();
      r = m_ready();
      inv   = {xer_valid_in, op2_valid_in, op1_valid_in};
      inval = {xer_in, op2_in, op1_in};
      intag = {xer_rs_id_in, op2_rs_id_in, op1_rs_id_in};
      cval  = {cdb_xer, cdb_result, cdb_result};
      for (int i = 0; i < DEPTH; i++) nxt[i] = m_ent[i];
      for (int i = 0; i < DEPTH; i++)
        if (m_ent[i].busy)
          for (int k = 0; k < 3; k++)
            if (!m_ent[i].v[k] && cdb_hits(k, m_ent[i].tag[k])) begin
              nxt[i].v[k] = 1'b1;
              nxt[i].val[k] = cval[k];
            end
      if (!m_iv || issue_ready) begin
        m_iv = (r >= 0);
        if (r >= 0) begin
          m_id = IDW'(OFF + r);
          m_dest = m_ent[r].dest;
          m_ctrl = m_ent[r].ctrl;
          for (int k = 0; k < 3; k++) m_op[k] = m_ent[r].val[k];
          nxt[r].busy = 1'b0;
        end
      end
      if (dispatch_valid && f >= 0) begin
        nxt[f].busy = 1'b1;
        nxt[f].dest = result_reg_addr_in;
        nxt[f].ctrl = control_in;
        for (int k = 0; k < 3; k++) begin
          nxt[f].tag[k] = intag[k];
          if (inv[k]) begin
            nxt[f].v[k] = 1'b1; nxt[f].val[k] = inval[k];
          end else if (cdb_hits(k, intag[k])) begin
            nxt[f].v[k] = 1'b1; nxt[f].val[k] = cval[k];
          end else begin
            nxt[f].v[k] = 1'b0; nxt[f].val[k] = '0;
          end
        end
      end
      for (int i = 0; i < DEPTH; i++) m_ent[i] = nxt[i];
    end
  endtask

  task automatic cycle();
    #1;
    if (m_known) begin
      chk("dispatch_ready", 32'(dispatch_ready), 32'(m_free() >= 0));
      if (m_free() >= 0) chk("dispatch_rs_id", 32'(dispatch_rs_id), 32'(OFF + m_free()));
    end
    model_step();
    @(posedge clk);
    #1;
    chk("issue_valid", 32'(issue_valid), 32'(m_iv));
    if (m_iv) begin
      chk("issue_rs_id", 32'(issue_rs_id), 32'(m_id));
      chk("issue_dest", 32'(issue_result_reg_addr), 32'(m_dest));
      chk("issue_op1", issue_op1, m_op[0]);
      chk("issue_op2", issue_op2, m_op[1]);
      chk("issue_xer", issue_xer, m_op[2]);
      chk("issue_control", 32'(ic), 32'(m_ctrl));
    end
  endtask

  task automatic idle();
    dispatch_valid = 0;
    op1_valid_in = 0; op2_valid_in = 0; xer_valid_in = 0;
    op1_in = '0; op2_in = '0; xer_in = '0;
    op1_rs_id_in = '0; op2_rs_id_in = '0; xer_rs_id_in = '0;
    result_reg_addr_in = '0; control_in = '0;
    cdb_valid = 0; cdb_rs_id = '0; cdb_result = '0; cdb_xer = '0; cdb_xer_valid = 0;
  endtask

  task automatic disp(input logic v1, input logic [31:0] o1, input logic [IDW-1:0] t1,
                      input logic v2, input logic [31:0] o2, input logic [IDW-1:0] t2,
                      input logic vx, input logic [31:0] x, input logic [IDW-1:0] tx,
                      input logic [4:0] d, input logic [3:0] c);
    dispatch_valid = 1;
    op1_valid_in = v1; op1_in = o1; op1_rs_id_in = t1;
    op2_valid_in = v2; op2_in = o2; op2_rs_id_in = t2;
    xer_valid_in = vx; xer_in = x; xer_rs_id_in = tx;
    result_reg_addr_in = d; control_in = mul_decode_t'(c);
  endtask

  task automatic cdb(input logic [IDW-1:0] t, input logic [31:0] r, input logic [31:0] x, input logic xv);
    cdb_valid = 1; cdb_rs_id = t; cdb_result = r; cdb_xer = x; cdb_xer_valid = xv;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    cycle();
    rst = 0;
  endtask

  function automatic logic [IDW-1:0] pick();
    case ($urandom_range(0, 4))
      0: return 5'd1;
      1: return 5'd2;
      2: return 5'd3;
      3: return 5'd8;
      default: return 5'd9;
    endcase
  endfunction

  typedef struct {
    logic [31:0] op1, op2, xer;
    logic [4:0]  dest;
    logic [3:0]  ctrl;
    logic [31:0] e_op1, e_op2, e_xer;
    logic [4:0]  e_dest;
    logic [3:0]  e_ctrl;
    logic [IDW-1:0] e_id;
  } vec_t;

  vec_t vt [5];

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{32'd7, 32'd6, 32'd0, 5'd3, 4'h0, 32'd7, 32'd6, 32'd0, 5'd3, 4'h0, 5'd8};
    vt[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h20000000, 5'd31, 4'hF,
              32'hFFFFFFFF, 32'hFFFFFFFF, 32'h20000000, 5'd31, 4'hF, 5'd8};
    vt[2] = '{32'd0, 32'd0, 32'd0, 5'd0, 4'h5, 32'd0, 32'd0, 32'd0, 5'd0, 4'h5, 5'd8};
    vt[3] = '{32'h80000000, 32'd1, 32'hFFFFFFFF, 5'd17, 4'hA,
              32'h80000000, 32'd1, 32'hFFFFFFFF, 5'd17, 4'hA, 5'd8};
    vt[4] = '{32'h12345678, 32'h9ABCDEF0, 32'd1, 5'd1, 4'h3,
              32'h12345678, 32'h9ABCDEF0, 32'd1, 5'd1, 4'h3, 5'd8};

    rst = 0; issue_ready = 1;
    idle();
    do_reset();
    chk("reset_issue_valid", 32'(issue_valid), 32'd0);
    chk("reset_dispatch_ready", 32'(dispatch_ready), 32'd1);
    chk("reset_dispatch_rs_id", 32'(dispatch_rs_id), 32'(OFF));

    // Table: all-valid dispatch issues exactly two edges later
    for (int n = 0; n < 5; n++) begin
      issue_ready = 1;
      disp(1, vt[n].op1, '0, 1, vt[n].op2, '0, 1, vt[n].xer, '0, vt[n].dest, vt[n].ctrl);
      cycle();
      idle();
      chk("vec_early_iv", 32'(issue_valid), 32'd0);
      cycle();
      chk("vec_iv", 32'(issue_valid), 32'd1);
      chk("vec_op1", issue_op1, vt[n].e_op1);
      chk("vec_op2", issue_op2, vt[n].e_op2);
      chk("vec_xer", issue_xer, vt[n].e_xer);
      chk("vec_dest", 32'(issue_result_reg_addr), 32'(vt[n].e_dest));
      chk("vec_ctrl", 32'(ic), 32'(vt[n].e_ctrl));
      chk("vec_id", 32'(issue_rs_id), 32'(vt[n].e_id));
      cycle();
    end

    // op1 waits on tag 3; broadcast three cycles after dispatch
    do_reset(); issue_ready = 1;
    disp(0, '0, 5'd3, 1, 32'd2, '0, 1, '0, '0, 5'd4, 4'h1);
    cycle(); idle();
    cycle(); cycle();
    cdb(5'd3, 32'h12345678, '0, 0);
    cycle(); idle();
    chk("cdb_capture_iv", 32'(issue_valid), 32'd0);
    cycle();
    chk("cdb_issue_iv", 32'(issue_valid), 32'd1);
    chk("cdb_issue_op1", issue_op1, 32'h12345678);
    chk("cdb_issue_op2", issue_op2, 32'd2);

    // Fill both entries behind a stalled issue register
    do_reset(); issue_ready = 0;
    disp(1, 32'd11, '0, 1, 32'd1, '0, 1, '0, '0, 5'd1, 4'h0); cycle();
    disp(1, 32'd22, '0, 1, 32'd2, '0, 1, '0, '0, 5'd2, 4'h0); cycle();
    disp(1, 32'd33, '0, 1, 32'd3, '0, 1, '0, '0, 5'd3, 4'h0); cycle();
    idle();
    chk("full_dispatch_ready", 32'(dispatch_ready), 32'd0);
    cycle(); cycle();
    chk("stall_iv", 32'(issue_valid), 32'd1);
    chk("stall_op1", issue_op1, 32'd11);
    chk("stall_dest", 32'(issue_result_reg_addr), 32'd1);
    chk("stall_dispatch_ready", 32'(dispatch_ready), 32'd0);
    issue_ready = 1;
    cycle();
    chk("release_dispatch_ready", 32'(dispatch_ready), 32'd1);
    chk("release_op1", issue_op1, 32'd33);
    chk("release_id", 32'(issue_rs_id), 32'(OFF));
    cycle();
    chk("second_op1", issue_op1, 32'd22);
    chk("second_id", 32'(issue_rs_id), 32'(OFF + 1));
    cycle();

    // Broadcast in the dispatch cycle is forwarded into the new entry
    do_reset(); issue_ready = 1;
    disp(0, '0, 5'd4, 1, 32'd3, '0, 1, '0, '0, 5'd7, 4'h2);
    cdb(5'd4, 32'hCAFEF00D, '0, 0);
    cycle(); idle();
    cycle();
    chk("fwd_iv", 32'(issue_valid), 32'd1);
    chk("fwd_op1", issue_op1, 32'hCAFEF00D);

    // One broadcast wakes two entries waiting on tag 2
    do_reset(); issue_ready = 1;
    disp(0, '0, 5'd2, 1, 32'd10, '0, 1, '0, '0, 5'd5, 4'h0); cycle();
    disp(1, 32'd20, '0, 0, '0, 5'd2, 1, '0, '0, 5'd6, 4'h0); cycle();
    idle();
    cdb(5'd2, 32'h55, '0, 0);
    cycle(); idle();
    chk("dual_capture_iv", 32'(issue_valid), 32'd0);
    cycle();
    chk("dual_first_id", 32'(issue_rs_id), 32'(OFF));
    chk("dual_first_op1", issue_op1, 32'h55);
    cycle();
    chk("dual_second_iv", 32'(issue_valid), 32'd1);
    chk("dual_second_id", 32'(issue_rs_id), 32'(OFF + 1));
    chk("dual_second_op2", issue_op2, 32'h55);
    cycle();

    // xer needs cdb_xer_valid; foreign tags ignored; own tag is an ordinary tag
    do_reset(); issue_ready = 1;
    disp(1, 32'd5, '0, 0, '0, 5'(OFF), 0, '0, 5'd3, 5'd9, 4'h0); cycle();
    idle(); cdb(5'd3, 32'h1111, 32'h2222, 0); cycle();
    idle(); cdb(5'd7, 32'hDEAD, 32'hBEEF, 1); cycle();
    idle(); cdb(5'(OFF), 32'h0BAD0BAD, 32'h9999, 1); cycle();
    idle(); cycle();
    chk("xer_wait_iv", 32'(issue_valid), 32'd0);
    cdb(5'd3, '0, 32'hABCD0123, 1); cycle();
    idle(); cycle();
    chk("xer_iv", 32'(issue_valid), 32'd1);
    chk("xer_val", issue_xer, 32'hABCD0123);
    chk("selftag_op2", issue_op2, 32'h0BAD0BAD);
    chk("selftag_op1", issue_op1, 32'd5);

    // Reset overrides dispatch, broadcast and handshake together
    do_reset(); issue_ready = 0;
    disp(1, 32'd1, '0, 1, 32'd2, '0, 1, '0, '0, 5'd1, 4'h1); cycle();
    disp(1, 32'd3, '0, 1, 32'd4, '0, 1, '0, '0, 5'd2, 4'h1); cycle();
    chk("pre_rst_iv", 32'(issue_valid), 32'd1);
    rst = 1; issue_ready = 1;
    cdb(5'(OFF), 32'h77, 32'h77, 1);
    cycle();
    rst = 0; idle();
    chk("rst_iv", 32'(issue_valid), 32'd0);
    chk("rst_dispatch_ready", 32'(dispatch_ready), 32'd1);
    chk("rst_dispatch_rs_id", 32'(dispatch_rs_id), 32'(OFF));
    chk("rst_op1", issue_op1, 32'd0);
    chk("rst_op2", issue_op2, 32'd0);
    chk("rst_id", 32'(issue_rs_id), 32'd0);
    chk("rst_dest", 32'(issue_result_reg_addr), 32'd0);

    // Randomized traffic against the reference
    for (int n = 0; n < 400; n++) begin
      idle();
      issue_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1)
        disp(1'($urandom_range(0, 1)), $urandom, pick(),
             1'($urandom_range(0, 1)), $urandom, pick(),
             1'($urandom_range(0, 1)), $urandom, pick(),
             5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 2) == 0)
        cdb(pick(), $urandom, $urandom, 1'($urandom_range(0, 1)));
      if (n == 200) rst = 1;
      cycle();
      rst = 0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mul_reservation_station.md
MUL_RESERVATION_STATION -- requirements
Module: mul_reservation_station

Interface
REQ-001 SHALL have parameters: RS_ID_WIDTH, default 5, tag width; RS_OFFSET, default 0, tag of entry 0; RS_DEPTH, default 2, entry count; RS_OFFSET+RS_DEPTH SHALL be <= 2**RS_ID_WIDTH.
REQ-002 SHALL have these ports, in order:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- dispatch_valid  in  1  dispatch offered
- dispatch_ready  out  1  a free entry exists
- dispatch_rs_id  out  RS_ID_WIDTH  tag the current dispatch will receive
- op1_valid_in, op2_valid_in, xer_valid_in  in  1 each  operand already available
- op1_in, op2_in, xer_in  in  32 each  operand value, or don't-care
- op1_rs_id_in, op2_rs_id_in, xer_rs_id_in  in  RS_ID_WIDTH each  producer tag when operand not valid
- result_reg_addr_in  in  5  destination GPR
- control_in  in  mul_decode_t  decoded multiply control
- cdb_valid  in  1  result broadcast
- cdb_rs_id  in  RS_ID_WIDTH  producer tag
- cdb_result  in  32  GPR value
- cdb_xer  in  32  XER value
- cdb_xer_valid  in  1  broadcast carries XER
- issue_valid  out  1  registered issue toward multiply unit
- issue_ready  in  1  multiply unit accepts
- issue_rs_id  out  RS_ID_WIDTH  tag of issued instruction
- issue_result_reg_addr  out  5  destination GPR
- issue_op1, issue_op2, issue_xer  out  32 each  resolved operands
- issue_control  out  mul_decode_t  control

Function
REQ-003 Entry i SHALL carry tag RS_OFFSET+i; dispatch_rs_id SHALL be the tag of the lowest-index free entry.
REQ-004 dispatch_ready SHALL be 1 iff at least one entry is free at the start of the cycle; it SHALL NOT depend on dispatch_valid.
REQ-005 On dispatch_valid&dispatch_ready, the lowest free entry SHALL become busy next cycle with all dispatch fields captured.
REQ-006 A non-valid operand SHALL wait on its tag; a snooped operand SHALL capture cdb_result, and a waiting xer SHALL capture cdb_xer only when cdb_xer_valid=1, on cdb_valid with matching tag.
REQ-007 When a CDB match occurs in the same cycle as dispatch, the dispatched entry SHALL capture the CDB value (same-cycle forwarding).
REQ-008 One broadcast SHALL update every matching operand in every busy entry simultaneously.
REQ-009 An entry SHALL be ready when busy and op1, op2 and xer are all valid.
REQ-010 The output register SHALL load when (~issue_valid | issue_ready); it SHALL load the lowest-index ready entry, setting issue_valid=1, or clear issue_valid if no entry is ready.
REQ-011 The entry loaded into the output register SHALL become free in the same edge; its slot is reportable as free the following cycle.
REQ-012 A ready entry whose operand was captured by the CDB at edge N SHALL be issuable at edge N+1; minimum dispatch-to-issue_valid latency is 2 edges.
REQ-013 While issue_valid=1 and issue_ready=0, all issue_* outputs SHALL be held stable.
REQ-014 A CDB broadcast for a tag not present SHALL have no effect; a CDB tag equal to a waiting entry's own tag SHALL be treated like any other tag.

Reset
REQ-015 On rst=1 at a clock edge, every entry SHALL become free, issue_valid=0, and all issue_* data, operands and tags SHALL be 0.
REQ-016 rst SHALL override a simultaneous dispatch, CDB broadcast and issue handshake; in-flight contents are discarded.

Structure
REQ-017 mul_decode_t SHALL come from ppc_types.
REQ-018 A new rs_operand_t typedef SHALL be added to ppc_types: valid bit, RS_ID_WIDTH tag and 32-bit value (tag width fixed at 5 in the package).
REQ-019 One sub-module, rs_operand_capture, SHALL implement the per-operand wait, snoop and capture logic, instantiated three times per entry.

Verification
REQ-020 Dispatch with all operands valid (op1=7, op2=6, xer=0), issue_ready=1 -> issue_valid=1 two edges later, issue_op1=7, issue_op2=6, issue_rs_id=RS_OFFSET.
REQ-021 Dispatch op1 waiting on tag 3, then cdb_valid with tag 3 and result 0x12345678 three cycles later -> issue_op1=0x12345678 exactly one edge after capture.
REQ-022 Fill both entries, hold issue_ready=0 -> dispatch_ready=0 with the first issue held stable; raise issue_ready -> dispatch_ready=1 the following cycle.
REQ-023 Dispatch waiting on tag 4 while cdb_valid with tag 4 occurs in the same cycle -> the entry captures the CDB value and issues without a further broadcast.
REQ-024 Two entries waiting on the same tag 2 -> one broadcast readies both; issue order is entry 0, then entry 1.
REQ-025 Assert rst with one entry busy and issue_valid=1 -> next cycle issue_valid=0, dispatch_ready=1, dispatch_rs_id=RS_OFFSET.
